parallel_bus_master: RTL and testbench
======================================

PARALLEL_BUS_MASTER -- requirements
Module: parallel_bus_master

Interface
REQ-001 The module SHALL have a parameter BUS_WIDTH, default 8, giving the parallel bus width in bits.
REQ-002 The module SHALL have a parameter TRANSACTIONS_PER_ADDRESS_WORD, default 2, giving the number of address beats per transaction.
REQ-003 The module SHALL have a parameter TRANSACTIONS_PER_DATA_WORD, default 2, giving the number of data beats per transaction.
REQ-004 The module SHALL have a parameter SETUP_CYCLES, default 2, giving the clock50 cycles that bus, read and register_select are held stable before enable rises.
REQ-005 The module SHALL have a parameter TIMEOUT_CYCLES, default 1023, giving the maximum number of cycles spent waiting for any single ack edge.
REQ-006 Port: clock50  in  1  system clock; all logic on its rising edge.
REQ-007 Port: reset  in  1  reset, synchronous, active-high.
REQ-008 Port: start  in  1  single-cycle request; sampled only in IDLE.
REQ-009 Port: write  in  1  transaction type, 1=write, 0=read; sampled with start.
REQ-010 Port: address_word  in  TPA*BUS_WIDTH  target address; sampled with start.
REQ-011 Port: write_data_word  in  TPD*BUS_WIDTH  write payload; sampled with start.
REQ-012 Port: busy  out  1  high in every state except IDLE.
REQ-013 Port: done  out  1  one-cycle pulse at the end of each transaction.
REQ-014 Port: timeout_error  out  1  one-cycle pulse coincident with done when the transaction aborted.
REQ-015 Port: read_data_word  out  TPD*BUS_WIDTH  assembled read payload; valid from done onward.
REQ-016 Port: bus_out  out  BUS_WIDTH  value driven onto the bus.
REQ-017 Port: bus_oe  out  1  bus output enable; equals ~read.
REQ-018 Port: bus_in  in  BUS_WIDTH  bus value returned by the responder.
REQ-019 Port: register_select  out  1  0=address beat, 1=data beat.
REQ-020 Port: read  out  1  0=write beat, 1=read beat.
REQ-021 Port: enable  out  1  beat strobe, active high.
REQ-022 Port: ack_valid  in  1  responder acknowledge; asynchronous to clock50.

Function
REQ-023 ack_valid SHALL be passed through a 2-flop synchronizer; "ack" below refers to the synchronized value only.
REQ-024 The FSM SHALL have the states IDLE, SETUP, STROBE, RELEASE and FINISH.
REQ-025 IDLE->SETUP on start: capture all inputs, beat counter=0, phase=address.
REQ-026 Beat order SHALL be the address beats, most significant first, then the data beats, most significant first.
REQ-027 Address beats: register_select=0, read=0, bus_out=the selected address slice.
REQ-028 Data beats in a write: register_select=1, read=0, bus_out=the selected write slice.
REQ-029 Data beats in a read: register_select=1, read=1, bus_oe=0.
REQ-030 SETUP SHALL hold the beat signals for SETUP_CYCLES cycles, then go to STROBE.
REQ-031 STROBE: enable=1; on ack=1 go to RELEASE. On a read beat, bus_in SHALL be captured into its slice in that same cycle.
REQ-032 RELEASE: enable=0; on ack=0, advance to the next beat's SETUP, or to FINISH after the last beat.
REQ-033 A read beat SHALL drop read to 0 only after the last beat's RELEASE completes; bus_oe SHALL never be 1 while read=1.
REQ-034 FINISH SHALL last 1 cycle, pulse done, then return to IDLE.
REQ-035 start asserted while busy SHALL be ignored; there is no queueing.
REQ-036 With TPA=TPD=2, a write SHALL consist of exactly 4 enable pulses.
REQ-037 Beat counters SHALL be $clog2-sized and SHALL NOT wrap past the final beat.

Reset
REQ-038 Reset SHALL win over all other activity, including mid-beat.
REQ-039 Reset SHALL force: state=IDLE, enable=0, read=0, register_select=0, bus_out=0, busy=0, done=0, timeout_error=0, read_data_word=0, synchronizer=0.
REQ-040 A transaction interrupted by reset SHALL produce no done pulse.

Configuration
REQ-041 With PARALLEL_BUS_MASTER_TIMEOUT_EN defined, a per-edge counter SHALL run in STROBE and RELEASE, reset on every state change.
REQ-042 On reaching TIMEOUT_CYCLES the module SHALL drop enable, go to FINISH, and pulse done together with timeout_error; read_data_word keeps its partial content.
REQ-043 Without PARALLEL_BUS_MASTER_TIMEOUT_EN the module SHALL wait indefinitely, and timeout_error SHALL be tied to 0.

Verification
REQ-044 Write scenario: address 0xab4c, data 0x2a12, responder model acks after 3 cycles -> the bus shows 0xab, 0x4c, 0x2a, 0x12 with register_select 0,0,1,1, then one done pulse.
REQ-045 Read scenario: address 0xab4c, responder returns 0x2a then 0x12 -> read_data_word=0x2a12 at done, and bus_oe=0 throughout both read beats.
REQ-046 Ack held high for 20 cycles -> enable stays low, and the next beat starts only after ack falls.
REQ-047 With PARALLEL_BUS_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=15, no ack -> done and timeout_error pulse together 15 cycles after enable rises, and enable returns to 0.
REQ-048 Reset asserted during the second data beat -> all outputs return to reset values the next cycle, no done pulse occurs, and a following start runs normally.
REQ-049 start pulsed while busy -> ignored; exactly one done pulse results.

Source files
------------

// File: rtl/parallel_bus_master.sv
// Parallel bus master: sequences address and data beats with a setup/strobe/release handshake.
// Optional per-edge ack timeout is enabled by defining PARALLEL_BUS_MASTER_TIMEOUT_EN.
module parallel_bus_master #(
  parameter int BUS_WIDTH                    = 8,
  parameter int TRANSACTIONS_PER_ADDRESS_WORD = 2,
  parameter int TRANSACTIONS_PER_DATA_WORD    = 2,
  parameter int SETUP_CYCLES                 = 2,
  parameter int TIMEOUT_CYCLES               = 1023
) (
  input  logic                                            clock50,
  input  logic                                            reset,
  input  logic                                            start,
  input  logic                                            write,
  input  logic [TRANSACTIONS_PER_ADDRESS_WORD*BUS_WIDTH-1:0] address_word,
  input  logic [TRANSACTIONS_PER_DATA_WORD*BUS_WIDTH-1:0]    write_data_word,
  output logic                                            busy,
  output logic                                            done,
  output logic                                            timeout_error,
  output logic [TRANSACTIONS_PER_DATA_WORD*BUS_WIDTH-1:0]    read_data_word,
  output logic [BUS_WIDTH-1:0]                            bus_out,
  output logic                                            bus_oe,
  input  logic [BUS_WIDTH-1:0]                            bus_in,
  output logic                                            register_select,
  output logic                                            read,
  output logic                                            enable,
  input  logic                                            ack_valid
);

  localparam int TPA  = TRANSACTIONS_PER_ADDRESS_WORD;
  localparam int TPD  = TRANSACTIONS_PER_DATA_WORD;
  localparam int MAXB = (TPA > TPD) ? TPA : TPD;
  localparam int BW   = (MAXB > 1) ? $clog2(MAXB) : 1;
  localparam int SW   = (SETUP_CYCLES > 0) ? $clog2(SETUP_CYCLES + 1) : 1;

  localparam logic [BW-1:0] ADDR_LAST  = BW'(TPA - 1);
  localparam logic [BW-1:0] DATA_LAST  = BW'(TPD - 1);
  localparam logic [SW-1:0] SETUP_LAST = (SETUP_CYCLES > 0) ? SW'(SETUP_CYCLES - 1) : '0;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETUP   = 3'd1;
  localparam logic [2:0] STROBE  = 3'd2;
  localparam logic [2:0] RELEASE = 3'd3;
  localparam logic [2:0] FINISH  = 3'd4;

  logic [2:0]                      state;
  logic                            ack_meta, ack;
  logic                            wr_q;
  logic [TPA-1:0][BUS_WIDTH-1:0]   addr_q;
  logic [TPD-1:0][BUS_WIDTH-1:0]   wdata_q;
  logic [TPD-1:0][BUS_WIDTH-1:0]   rdata_q;
  logic                            phase;      // 0 = address beats, 1 = data beats
  logic [BW-1:0]                   beat;
  logic [SW-1:0]                   setup_cnt;
  logic [BW-1:0]                   addr_sel, data_sel;
  logic                            in_beat, last_beat, rd_beat;

  // Slices go out most significant first.
  assign addr_sel  = ADDR_LAST - beat;
  assign data_sel  = DATA_LAST - beat;
  assign in_beat   = (state == SETUP) || (state == STROBE) || (state == RELEASE);
  assign last_beat = phase && (beat == DATA_LAST);
  assign rd_beat   = phase && !wr_q;

`ifdef PARALLEL_BUS_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  logic          to_flag, waiting, leaving, to_hit;

  assign waiting = (state == STROBE) || (state == RELEASE);
  assign leaving = ((state == STROBE) && ack) || ((state == RELEASE) && !ack);
  assign to_hit  = waiting && !leaving && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Counts cycles spent waiting on one ack edge; cleared on every state change.
  always_ff @(posedge clock50) begin
    if (reset || !waiting || leaving || to_hit) to_cnt <= '0;
    else                                        to_cnt <= to_cnt + 1'b1;
  end

  assign timeout_error = (state == FINISH) && to_flag;
`else
  assign timeout_error = 1'b0;
`endif

  always_ff @(posedge clock50) begin
    if (reset) begin
      ack_meta  <= 1'b0;
      ack       <= 1'b0;
      state     <= IDLE;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      phase     <= 1'b0;
      beat      <= '0;
      setup_cnt <= '0;
`ifdef PARALLEL_BUS_MASTER_TIMEOUT_EN
      to_flag   <= 1'b0;
`endif
    end else begin
      ack_meta <= ack_valid;
      ack      <= ack_meta;
      case (state)
        IDLE: begin
          if (start) begin
            wr_q      <= write;
            addr_q    <= address_word;
            wdata_q   <= write_data_word;
            rdata_q   <= '0;
            phase     <= 1'b0;
            beat      <= '0;
            setup_cnt <= '0;
`ifdef PARALLEL_BUS_MASTER_TIMEOUT_EN
            to_flag   <= 1'b0;
`endif
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (setup_cnt == SETUP_LAST) begin
            setup_cnt <= '0;
            state     <= STROBE;
          end else begin
            setup_cnt <= setup_cnt + 1'b1;
          end
        end
        STROBE: begin
          if (ack) begin
            if (rd_beat) rdata_q[data_sel] <= bus_in;
            state <= RELEASE;
          end
`ifdef PARALLEL_BUS_MASTER_TIMEOUT_EN
          else if (to_hit) begin
            to_flag <= 1'b1;
            state   <= FINISH;
          end
`endif
        end
        RELEASE: begin
          if (!ack) begin
            if (last_beat) begin
              state <= FINISH;
            end else begin
              if (!phase && (beat == ADDR_LAST)) begin
                phase <= 1'b1;
                beat  <= '0;
              end else begin
                beat  <= beat + 1'b1;
              end
              state <= SETUP;
            end
          end
`ifdef PARALLEL_BUS_MASTER_TIMEOUT_EN
          else if (to_hit) begin
            to_flag <= 1'b1;
            state   <= FINISH;
          end
`endif
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Beat signals decode straight from registered state so reset clears them next cycle.
  always_comb begin
    bus_out = '0;
    if (in_beat && !phase)      bus_out = addr_q[addr_sel];
    else if (in_beat && wr_q)   bus_out = wdata_q[data_sel];
  end

  assign register_select = in_beat && phase;
  assign read            = in_beat && rd_beat;
  assign bus_oe          = ~read;
  assign enable          = (state == STROBE);
  assign busy            = (state != IDLE);
  assign done            = (state == FINISH);
  assign read_data_word  = rdata_q;

endmodule

// File: tb/tb_parallel_bus_master.sv
// Scoreboard bench for parallel_bus_master: expected beats and done results are queued
// at issue time and popped by monitors on each enable rise and each done pulse.
module tb_parallel_bus_master;

`ifdef PARALLEL_BUS_MASTER_TIMEOUT_EN
  localparam int TO_CYC = 15;
  localparam int HOLD_LONG = 10;
`else
  localparam int TO_CYC = 1023;
  localparam int HOLD_LONG = 20;
`endif

  logic        clock50 = 0;
  logic        reset = 1;
  logic        start = 0;
  logic        write = 0;
  logic [15:0] address_word = 0;
  logic [15:0] write_data_word = 0;
  logic        busy, done, timeout_error;
  logic [15:0] read_data_word;
  logic [7:0]  bus_out;
  logic        bus_oe;
  logic [7:0]  bus_in = 0;
  logic        register_select, read, enable;
  logic        ack_valid = 0;

  parallel_bus_master #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clock50(clock50), .reset(reset), .start(start), .write(write),
    .address_word(address_word), .write_data_word(write_data_word),
    .busy(busy), .done(done), .timeout_error(timeout_error),
    .read_data_word(read_data_word), .bus_out(bus_out), .bus_oe(bus_oe),
    .bus_in(bus_in), .register_select(register_select), .read(read),
    .enable(enable), .ack_valid(ack_valid)
  );

  always #10 clock50 = ~clock50;

  typedef struct { logic to; logic chk; logic [15:0] rd; } done_t;
  done_t       exp_done[$];
  logic [11:0] exp_beat[$];   // {rs, read, bus_oe, ack_valid, bus_out}
  logic [7:0]  rd_q[$];

  int checks = 0, passed = 0;
  int cyc = 0, done_cnt = 0, beats_seen = 0, t_rise = 0, t_done = 0;
  int hold = 1;
  logic resp_en = 1, en_prev = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clock50) cyc++;

  // Beat monitor
  always @(negedge clock50) begin
    if (enable && !en_prev) begin
      beats_seen++;
      t_rise = cyc;
      if (exp_beat.size() == 0) check("extra_beat", {register_select, read, bus_out}, 0);
      else check("beat", {register_select, read, bus_oe, ack_valid, read ? 8'h00 : bus_out},
                 exp_beat.pop_front());
    end
    en_prev = enable;
  end

  // Done monitor
  always @(negedge clock50) begin
    if (done) begin
      done_t e;
      done_cnt++;
      t_done = cyc;
      if (exp_done.size() == 0) check("unexpected_done", done, 0);
      else begin
        e = exp_done.pop_front();
        check("done_flags", {timeout_error, busy, enable}, {e.to, 1'b1, 1'b0});
        if (e.chk) check("read_data", read_data_word, e.rd);
      end
    end
  end

  // Responder: acks 3 cycles after enable, holds ack `hold` cycles after enable drops.
  initial forever begin
    @(posedge clock50); #1;
    if (enable && resp_en) begin
      repeat (3) @(posedge clock50);
      #1;
      if (read && rd_q.size() > 0) bus_in = rd_q.pop_front();
      ack_valid = 1;
      for (int k = 0; k < 200 && enable; k++) begin @(posedge clock50); #1; end
      repeat (hold) @(posedge clock50);
      #1;
      ack_valid = 0;
    end
  end

  task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d,
                       input logic [15:0] rd_exp);
    for (int i = 0; i < 2; i++) exp_beat.push_back({4'b0010, a[15-8*i -: 8]});
    for (int i = 0; i < 2; i++)
      exp_beat.push_back(w ? {4'b1010, d[15-8*i -: 8]} : {4'b1100, 8'h00});
    if (!w) begin rd_q.push_back(rd_exp[15:8]); rd_q.push_back(rd_exp[7:0]); end
    exp_done.push_back('{to: 1'b0, chk: !w, rd: rd_exp});
    @(posedge clock50); #1;
    start = 1; write = w; address_word = a; write_data_word = d;
    @(posedge clock50); #1;
    start = 0;
  endtask

  task automatic wait_done(input string name);
    int base = done_cnt;
    for (int k = 0; k < 2000 && done_cnt == base; k++) @(posedge clock50);
    check(name, done_cnt > base, 1);
    @(posedge clock50); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dsave, target;
    repeat (3) @(posedge clock50);
    #1;
    check("reset_state",
          {busy, done, timeout_error, enable, read, register_select, bus_oe, bus_out, read_data_word},
          {7'b0000001, 8'h00, 16'h0000});
    reset = 0;

    // Write 0xab4c / 0x2a12
    issue(1, 16'hab4c, 16'h2a12, 16'h0);
    wait_done("write_done");

    // Read 0xab4c, responder returns 0x2a, 0x12
    issue(0, 16'hab4c, 16'h0, 16'h2a12);
    wait_done("read_done");

    // Ack held long after enable drops
    hold = HOLD_LONG;
    issue(1, 16'h1234, 16'h5678, 16'h0);
    wait_done("hold_done");
    hold = 1;

    // start while busy is ignored
    issue(1, 16'h0f0e, 16'hc0de, 16'h0);
    repeat (5) @(posedge clock50);
    #1;
    start = 1; write = 0; address_word = 16'hdead; write_data_word = 16'hbeef;
    @(posedge clock50); #1;
    start = 0;
    wait_done("busy_start_done");
    dsave = done_cnt;
    repeat (60) @(posedge clock50);
    check("single_done", done_cnt, dsave);

    // Reset during the second data beat of a read
    target = beats_seen + 4;
    issue(0, 16'h7e81, 16'h0, 16'h3c96);
    for (int k = 0; k < 500 && beats_seen < target; k++) @(negedge clock50);
    check("reached_beat4", beats_seen, target);
    @(posedge clock50); #1;
    reset = 1;
    exp_done.delete(); exp_beat.delete(); rd_q.delete();
    @(posedge clock50); #1;
    check("midbeat_reset",
          {busy, done, timeout_error, enable, read, register_select, bus_oe, bus_out, read_data_word},
          {7'b0000001, 8'h00, 16'h0000});
    reset = 0;
    dsave = done_cnt;
    repeat (30) @(posedge clock50);
    check("no_done_after_reset", done_cnt, dsave);

    // Normal read after reset
    issue(0, 16'h00ff, 16'h0, 16'h5aa5);
    wait_done("post_reset_read");

`ifdef PARALLEL_BUS_MASTER_TIMEOUT_EN
    // No ack at all: first beat times out
    resp_en = 0;
    exp_beat.push_back({4'b0010, 8'h99});
    exp_done.push_back('{to: 1'b1, chk: 1'b1, rd: 16'h0000});
    @(posedge clock50); #1;
    start = 1; write = 1; address_word = 16'h9911; write_data_word = 16'h2233;
    @(posedge clock50); #1;
    start = 0;
    wait_done("timeout_done");
    check("timeout_latency", t_done - t_rise, TO_CYC);
    resp_en = 1;
`endif

    repeat (10) @(posedge clock50);
    check("beat_q_empty", exp_beat.size(), 0);
    check("done_q_empty", exp_done.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
